// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial framed link (transmit and receive sides).
//   tx_state_e : frame sequencer states
//   LineIdle   : level of the serial line between frames
//   LineStart  : level of the start bit
//   ParityOdd  : parity-type selector; 0 gives even parity (parity bit = XOR of data)
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    localparam logic LineIdle  = 1'b1;
    localparam logic LineStart = 1'b0;
    localparam logic ParityOdd = 1'b0;

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer for the serial transmitter.
// Down-counter reloaded to BIT_CYCLES-1 by restart_i; bit_done_o is high in the last cycle
// of the current bit period (counter at zero). All updates on the falling clock edge.
// Ports:
//   clk_ni     clock, falling-edge active
//   clr_ni     synchronous active-low clear
//   restart_i  start a new bit period at this edge
//   bit_done_o current bit period ends at the next edge
module serial_frame_tx_bit_timer #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic clk_ni,
    input  logic clr_ni,
    input  logic restart_i,
    output logic bit_done_o
);

    localparam int unsigned TimW = $clog2(BIT_CYCLES) + 1;

    logic [TimW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = TimW'(BIT_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TimW'(1);
        end
    end

    always_ff @(negedge clk_ni) begin
        if (!clr_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done_o = (cnt_q == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framed transmitter.
// Accepts a WIDTH-bit word on an active-low load strobe while Ready=1 and sends
// start bit (0), data LSB first, optional even parity, stop bit (1), each held for
// BIT_CYCLES clocks. All state changes on the falling edge of ClkN; all outputs are flops.
// Optional feature: define SERIAL_TX_PARITY_EN to insert the parity bit before the stop bit.
// Ports:
//   ClkN      clock, falling-edge active
//   ClrN      synchronous active-low reset (aborts a frame in progress, no FrameEnd)
//   LoadN     active-low load request, honoured only while Ready=1
//   Din       parallel word, sampled on the accepting edge only
//   Ready     1 = idle, a load will be accepted at the next edge
//   SerOut    serial line, idles high
//   FrameEnd  one-cycle pulse after the stop bit completes
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic             ClkN,
    input  logic             ClrN,
    input  logic             LoadN,
    input  logic [WIDTH-1:0] Din,
    output logic             Ready,
    output logic             SerOut,
    output logic             FrameEnd
);

    localparam int unsigned IdxW = $clog2(WIDTH) + 1;

    tx_state_e        state_d, state_q;
    logic [WIDTH-1:0] shift_d, shift_q;
    logic [WIDTH-1:0] shifted;
    logic [IdxW-1:0]  idx_d, idx_q;
    logic             ser_d, ser_q;
    logic             ready_d, ready_q;
    logic             fend_d, fend_q;
    logic             restart;
    logic             bit_done;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_d, par_q;
`endif

    serial_frame_tx_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk_ni     (ClkN),
        .clr_ni     (ClrN),
        .restart_i  (restart),
        .bit_done_o (bit_done)
    );

    assign shifted = shift_q >> 1;

    // Next-state values are the line levels for the coming bit, so SerOut is a plain flop.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        ser_d   = ser_q;
        ready_d = ready_q;
        fend_d  = 1'b0;
        restart = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!LoadN) begin
                    state_d = StStart;
                    shift_d = Din;
                    idx_d   = '0;
                    ser_d   = LineStart;
                    ready_d = 1'b0;
                    restart = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = (^Din) ^ ParityOdd;
`endif
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                    ser_d   = shift_q[0];
                    restart = 1'b1;
                end
            end
            StData: begin
                if (bit_done) begin
                    restart = 1'b1;
                    if (idx_q == IdxW'(WIDTH - 1)) begin
                        idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = StParity;
                        ser_d   = par_q;
`else
                        state_d = StStop;
                        ser_d   = LineIdle;
`endif
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        shift_d = shifted;
                        ser_d   = shifted[0];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                    ser_d   = LineIdle;
                    restart = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_done) begin
                    state_d = StIdle;
                    ser_d   = LineIdle;
                    ready_d = 1'b1;
                    fend_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                ser_d   = LineIdle;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(negedge ClkN) begin
        if (!ClrN) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            ser_q   <= LineIdle;
            ready_q <= 1'b1;
            fend_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            ser_q   <= ser_d;
            ready_q <= ready_d;
            fend_q  <= fend_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign SerOut   = ser_q;
    assign Ready    = ready_q;
    assign FrameEnd = fend_q;

endmodule
